mem_responder: RTL and testbench
================================

# mem_responder

Target-side data-memory responder for the multicycle CPU. It accepts one load or store request at a time over a valid/ready handshake and performs it against an internal word-wide synchronous RAM. It handles byte, halfword and word sizes, including lane extraction and sign/zero extension on loads and read-modify-write merging on sub-word stores. It returns a single response per request, carrying the read data and an error flag for misaligned or reserved-size accesses.

## Interface
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (default 256 words = 1 KiB)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns FSM to IDLE
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present; held until accepted
- rsp_ready  in  1  response consumed on edge where rsp_valid && rsp_ready
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request

## Operation
- Request fields are registered on the accept edge and are not required to be held afterwards.
- Word index = req_addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size.
- Little-endian lanes:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits [15:0] when 0, [31:16] when 1).
- Error cases: size 11; half with addr[0]=1; word with addr[1:0]≠00.
  - An error request performs no RAM access.
  - FSM goes IDLE→RESP with rsp_err=1 and rsp_rdata=0.
- FSM states are IDLE, RD, WR, RESP. Transitions:
  - IDLE: on accept → RESP on error; → WR for word store; → RD otherwise.
  - RD: RAM word captured into word register; → RESP for a load; → WR for a sub-word store.
  - WR: RAM written at this edge with the merged word (sub-word) or req_wdata (word); → RESP.
  - RESP: rsp_valid=1; on rsp_ready → IDLE.
- Load formatting: select the lane, then extend per req_signed. A word load ignores req_signed.
- Sub-word store merge: replace only the addressed lane in the captured word; other lanes are unchanged.
- RAM contents are not reset.
- Reset at any point forces IDLE and clears rsp_valid, rsp_err and rsp_rdata.
  - A WR edge that coincides with or follows reset assertion does not write.
  - A write already completed on an earlier edge persists.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Latency is measured from the accept edge E0 to the cycle in which rsp_valid is first high:
  - Error: after E0 (1 edge).
  - Load: after E1 (2 edges).
  - Word store: after E1; write at E1.
  - Sub-word store: read at E1, write at E2, rsp_valid after E2.
- Minimum request spacing is 1 idle cycle, because req_ready rises only after the response handshake edge.
- req_ready=0 in RD, WR and RESP. req_valid asserted then is ignored and not queued.
- rsp_rdata and rsp_err are stable throughout RESP.
- A load issued immediately after a store to the same word returns the stored data, since the write completes before the load is accepted.
- Back-pressure: rsp_ready held low keeps RESP indefinitely with outputs unchanged.

## Structure
- Package mem_responder_pkg holds:
  - Size localparams SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - The state enum (IDLE, RD, WR, RESP).
  - The functions lane_extract(word, addr, size, signed) and lane_merge(word, addr, size, wdata).
- Sub-module mem_word_ram is the storage: a 2^DEPTH_LOG2 × 32 array with registered read, a single write port and write enable, and no reset.
- The top level contains the FSM, request/response registers and the error decode.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10 → rdata 0xDEADBEEF, err=0. Each response appears at the latency specified in Timing.
- Signed/unsigned byte load: after the word above, load byte 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE. Load half 0x10 signed → 0xFFFFBEEF.
- Sub-word store merge: store byte 0x55 at 0x11 → word at 0x10 reads 0xDEAD55EF. Store half 0x1234 at 0x12 → word reads 0x123455EF. Each store's rsp_valid appears after 3 edges.
- Misaligned/reserved: word at 0x12, half at 0x11, size 11 → rsp_err=1, rdata=0, rsp_valid after 1 edge. The word at 0x10 is unchanged afterwards.
- Back-pressure and wrap: hold rsp_ready=0 for 5 cycles → outputs stable, req_ready=0. With the default depth, a store to 0x410 aliases to 0x10 on a later load.
- Reset mid-operation: assert reset in WR of a byte store → no write, rsp_valid=0, req_ready=1 next cycle. The old word is intact.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared sizes, FSM states and lane helpers for mem_responder
package mem_responder_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // Pick the addressed little-endian lane out of a RAM word and extend it to
  // 32 bits. Word accesses pass through untouched, so sgn is irrelevant there.
  function automatic logic [31:0] lane_extract(
    input logic [31:0] word,
    input logic [1:0]  addr,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_res;
    case (addr)
      2'd0:    v_byte = word[7:0];
      2'd1:    v_byte = word[15:8];
      2'd2:    v_byte = word[23:16];
      default: v_byte = word[31:24];
    endcase
    v_half = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: v_res = {{24{sgn & v_byte[7]}}, v_byte};
      SZ_HALF: v_res = {{16{sgn & v_half[15]}}, v_half};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  // Replace only the addressed lane of a captured word with right-aligned
  // store data; untouched lanes keep their old contents.
  function automatic logic [31:0] lane_merge(
    input logic [31:0] word,
    input logic [1:0]  addr,
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] v_res;
    v_res = word;
    case (size)
      SZ_BYTE: begin
        case (addr)
          2'd0:    v_res[7:0]   = wdata[7:0];
          2'd1:    v_res[15:8]  = wdata[7:0];
          2'd2:    v_res[23:16] = wdata[7:0];
          default: v_res[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr[1]) v_res[31:16] = wdata[15:0];
        else         v_res[15:0]  = wdata[15:0];
      end
      default: v_res = wdata;
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - word-wide synchronous RAM with registered read, no reset
module mem_word_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic                  i_re,
  input  logic                  i_we,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];
  logic [31:0] r_rdata;

  // Single port: write when enabled; the read register only loads on i_re so
  // its value stays put for as long as the controller needs it.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata       <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - load/store responder: FSM, request registers, error decode
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_err;

  logic        w_accept;
  logic        w_req_err;
  logic        w_ram_re;
  logic        w_ram_we;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_ram_wdata;
  logic [31:0] w_load_data;

  // Address bits above the RAM window are deliberately dropped so accesses
  // wrap modulo the RAM size.
  logic w_addr_unused;
  assign w_addr_unused = ^i_req_addr[31:DEPTH_LOG2+2];

  assign w_accept = i_req_valid && o_req_ready;

  // Reserved size, odd halfword, or non-word-aligned word is refused.
  assign w_req_err = (i_req_size == SZ_RSVD) ||
                     ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                     ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));

  // State register; reset drops any transaction in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_we    = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_req_err)                              w_state_nxt = RESP;
          else if (i_req_we && i_req_size == SZ_WORD) w_state_nxt = WR;
          else                                        w_state_nxt = RD;
        end
      end
      RD: begin
        w_ram_re    = 1'b1;
        w_state_nxt = r_we ? WR : RESP;
      end
      WR: begin
        // A reset landing on this edge must not let the write through.
        w_ram_we    = !i_reset;
        w_state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the request on the accept edge so the requester may move on.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= i_req_we;
      r_size   <= i_req_size;
      r_signed <= i_req_signed;
      r_addr   <= i_req_addr[DEPTH_LOG2+1:0];
      r_wdata  <= i_req_wdata;
      r_err    <= w_req_err;
    end
  end

  // The RAM read register doubles as the captured word: it is loaded in RD
  // and holds through WR (merge source) and RESP (load result source).
  assign w_ram_wdata = (r_size == SZ_WORD) ? r_wdata
                                           : lane_merge(w_ram_rdata, r_addr[1:0], r_size, r_wdata);

  mem_word_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (i_clk),
    .i_addr  (r_addr[DEPTH_LOG2+1:2]),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_load_data = lane_extract(w_ram_rdata, r_addr[1:0], r_size, r_signed);

  // Response fields are derived only from registers that do not change in
  // RESP, so they stay stable under back-pressure and read zero elsewhere.
  assign o_rsp_err   = (r_state == RESP) && r_err;
  assign o_rsp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_load_data : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with random traffic
module tb_mem_responder;

  logic        clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  mem_responder #(.DEPTH_LOG2(8)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_size   (i_req_size),
    .i_req_signed (i_req_signed),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          seen = 0;
  bit          bp_en = 0;
  logic [31:0] hold_d;
  logic        hold_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: byte-addressed little-endian memory of 256 words, addresses
  // taken modulo 1 KiB.
  task automatic model(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int          idx;
    int          lo;
    logic [31:0] w;
    logic [31:0] v;
    idx = int'(addr[9:2]);
    lo  = int'(addr[1:0]);
    e.rdata = 32'h0;
    e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && lo != 0);
    e.acc   = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (we) begin
      w = mem[idx];
      if (size == 2'd2) begin
        w = wdata;
        e.lat = 2;
      end else begin
        if (size == 2'd0) w[8*lo +: 8] = wdata[7:0];
        else              w[16*(lo/2) +: 16] = wdata[15:0];
        e.lat = 3;
      end
      mem[idx] = w;
    end else begin
      w = mem[idx];
      e.lat = 2;
      if (size == 2'd0) begin
        v = (w >> (8*lo)) & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2'd1) begin
        v = (w >> (8*lo)) & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      e.rdata = v;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!o_req_ready) chk("req_ready_timeout", {31'h0, o_req_ready}, 32'h1);
  endtask

  // Issue one request; keep a garbage request on the bus one extra cycle to
  // show that nothing is accepted while busy.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    wait_ready();
    if (!o_req_ready) return;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_size   = size;
    i_req_signed = sgn;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    model(we, size, sgn, addr, wdata, e);
    @(posedge clk); #1;
    e.acc = cyc;
    q.push_back(e);
    i_req_we     = 1'($urandom);
    i_req_size   = 2'($urandom);
    i_req_signed = 1'($urandom);
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
    @(posedge clk); #1;
    i_req_valid  = 1'b0;
  endtask

  // Monitor: pop expectation on first cycle of each response, then require
  // the outputs to hold while back-pressured.
  always @(negedge clk) begin
    exp_t e;
    if (i_reset) begin
      seen = 0;
    end else if (o_rsp_valid) begin
      if (!seen) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata %h err %b with no request outstanding", o_rsp_rdata, o_rsp_err);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", o_rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, e.err});
          chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
        hold_d = o_rsp_rdata;
        hold_e = o_rsp_err;
      end else begin
        chk("hold_rdata", o_rsp_rdata, hold_d);
        chk("hold_err", {31'h0, o_rsp_err}, {31'h0, hold_e});
        chk("hold_req_ready", {31'h0, o_req_ready}, 32'h0);
      end
      seen = !i_rsp_ready;
    end
  end

  // Random back-pressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (bp_en) i_rsp_ready = ($urandom_range(3) != 0);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          n;
    i_reset      = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_size   = 2'd0;
    i_req_signed = 1'b0;
    i_req_addr   = 32'h0;
    i_req_wdata  = 32'h0;
    i_rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'h0, o_req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", o_rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, o_rsp_err}, 32'h0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    // Give every word a known value; upper address bits are random.
    for (int i = 0; i < 256; i++)
      do_req(1'b1, 2'd2, 1'b0, {$urandom_range(4194303), 8'(i), 2'b00}, $urandom);

    // Directed scenarios.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF);
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF);
    do_req(1'b0, 2'd3, 1'b1, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_ready();
    chk("word_0x10_after_merges", mem[4], 32'h123455EF);

    // Back-pressure: response held for several cycles.
    i_rsp_ready = 1'b0;
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_rsp_valid", {31'h0, o_rsp_valid}, 32'h1);
    chk("bp_req_ready", {31'h0, o_req_ready}, 32'h0);
    i_rsp_ready = 1'b1;

    // Wrap: 0x410 aliases word 0x10.
    do_req(1'b1, 2'd2, 1'b0, 32'h410, 32'hA5A5C3C3);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Reset while a byte store sits in WR: the write must be lost.
    wait_ready();
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_size   = 2'd0;
    i_req_signed = 1'b0;
    i_req_addr   = 32'h11;
    i_req_wdata  = 32'h77;
    @(posedge clk); #1;
    i_req_valid  = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    chk("rst_mid_req_ready", {31'h0, o_req_ready}, 32'h1);
    chk("rst_mid_rsp_rdata", o_rsp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_rsp_valid_after", {31'h0, o_rsp_valid}, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Random traffic with random back-pressure.
    bp_en = 1;
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      sz = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
      if ($urandom_range(1) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0]   = 1'b0;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    bp_en = 0;
    #2;
    i_rsp_ready = 1'b1;

    n = 0;
    while ((q.size() != 0 || !o_req_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_outstanding", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
